// File: rtl/user_io_mc.sv
// user_io_mc: user-I/O SPI slave between the IO-controller SPI link and the core.
// SPI pins are oversampled in the clk domain; no logic runs on SPI_CLK.
//
// State table (PS/2 transmitter):
//   S_IDLE  | lines high, waiting for a byte in the FIFO
//   S_LOAD  | pop FIFO head, build frame, drive start bit
//   S_SHIFT | 11 bits, each ps2_clk low PS2_DIV then high PS2_DIV
//   S_GAP   | one idle half-bit with both lines high
//
// Ports:
//   clk, reset_n         system clock, synchronous active-low reset
//   conf_str, core_type  OSD config string (first char in MSB byte), core id
//   SPI_CLK/SS_IO/MOSI   SPI inputs from the IO controller
//   SPI_MISO             SPI data out, high-Z while SPI_SS_IO is high
//   JOY, BUTTONS,        core-facing registers written over SPI
//   SWITCHES, status
//   ps2_clk, ps2_data    PS/2 keyboard lines, idle high
//   ps2_overflow         sticky: a keyboard byte was dropped (FIFO full)
module user_io_mc #(
    parameter int STRLEN    = 1,
    parameter int NUM_JOY   = 2,
    parameter int JOY_W     = 6,
    parameter int STATUS_W  = 8,
    parameter int PS2_DEPTH = 16,
    parameter int PS2_DIV   = 750
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [8*STRLEN-1:0]      conf_str,
    input  logic [7:0]               core_type,
    input  logic                     SPI_CLK,
    input  logic                     SPI_SS_IO,
    input  logic                     SPI_MOSI,
    output logic                     SPI_MISO,
    output logic [NUM_JOY*JOY_W-1:0] JOY,
    output logic [1:0]               BUTTONS,
    output logic [1:0]               SWITCHES,
    output logic [STATUS_W-1:0]      status,
    output logic                     ps2_clk,
    output logic                     ps2_data,
    output logic                     ps2_overflow
);

    localparam int AW    = $clog2(PS2_DEPTH);
    localparam int CW    = AW + 1;
    localparam int DIV_W = $clog2(PS2_DIV + 1);

    // ---------------------------------------------------------------- SPI
    logic                     r_sck_s1, r_sck_s2, r_sck_h;
    logic                     r_ss_s1, r_ss_s2;
    logic                     r_mosi_s1, r_mosi_s2;
    logic [2:0]               r_bit_cnt;
    logic [15:0]              r_byte_cnt;
    logic [6:0]               r_sr;
    logic [7:0]               r_cmd;
    logic [7:0]               r_tx;
    logic                     r_miso;
    logic [NUM_JOY*JOY_W-1:0] r_joy;
    logic [1:0]               r_buttons, r_switches;
    logic [STATUS_W-1:0]      r_status;

    logic                     w_sck_rise, w_sck_fall, w_byte_done, w_push;
    logic [7:0]               w_byte, w_conf_byte, w_tx_next;
    logic [15:0]              w_rd_idx;
    logic [2:0]               w_joy_sel;

    assign w_sck_rise  = r_sck_s2 & ~r_sck_h;
    assign w_sck_fall  = ~r_sck_s2 & r_sck_h;
    assign w_byte      = {r_sr, r_mosi_s2};
    assign w_byte_done = ~r_ss_s2 & w_sck_rise & (r_bit_cnt == 3'd7);
    assign w_push      = w_byte_done & (r_byte_cnt != 16'd0) & (r_cmd == 8'h05);
    assign w_rd_idx    = r_byte_cnt - 16'd1;

    always_comb begin
        w_joy_sel = 3'd7;
        case (r_cmd)
            8'h02:   w_joy_sel = 3'd0;
            8'h03:   w_joy_sel = 3'd1;
            8'h10:   w_joy_sel = 3'd2;
            8'h11:   w_joy_sel = 3'd3;
            default: w_joy_sel = 3'd7;
        endcase
    end

    always_comb begin
        w_conf_byte = 8'h00;
        for (int i = 0; i < STRLEN; i++) begin
            if (w_rd_idx == 16'(i))
                w_conf_byte = conf_str[(STRLEN-1-i)*8 +: 8];
        end
    end

    always_comb begin
        if (r_byte_cnt == 16'd0)
            w_tx_next = core_type;
        else if (r_cmd == 8'h14)
            w_tx_next = w_conf_byte;
        else
            w_tx_next = 8'h00;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sck_s1   <= 1'b0;
            r_sck_s2   <= 1'b0;
            r_sck_h    <= 1'b0;
            r_ss_s1    <= 1'b1;
            r_ss_s2    <= 1'b1;
            r_mosi_s1  <= 1'b0;
            r_mosi_s2  <= 1'b0;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 16'd0;
            r_sr       <= 7'd0;
            r_cmd      <= 8'h00;
            r_tx       <= 8'h00;
            r_miso     <= 1'b0;
            r_joy      <= '0;
            r_buttons  <= 2'b00;
            r_switches <= 2'b00;
            r_status   <= '0;
        end else begin
            r_sck_s1  <= SPI_CLK;
            r_sck_s2  <= r_sck_s1;
            r_sck_h   <= r_sck_s2;
            r_ss_s1   <= SPI_SS_IO;
            r_ss_s2   <= r_ss_s1;
            r_mosi_s1 <= SPI_MOSI;
            r_mosi_s2 <= r_mosi_s1;

            if (r_ss_s2) begin
                // Deselected: drop any partial byte and preload the core id
                // so its MSB is on MISO before the first rising edge.
                r_bit_cnt  <= 3'd0;
                r_byte_cnt <= 16'd0;
                r_sr       <= 7'd0;
                r_tx       <= core_type;
                r_miso     <= core_type[7];
            end else begin
                if (w_sck_rise) begin
                    r_sr      <= w_byte[6:0];
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        if (r_byte_cnt != 16'hFFFF)
                            r_byte_cnt <= r_byte_cnt + 16'd1;
                        if (r_byte_cnt == 16'd0) begin
                            r_cmd <= w_byte;
                        end else begin
                            if (r_cmd == 8'h01 && r_byte_cnt == 16'd1) begin
                                r_buttons  <= w_byte[1:0];
                                r_switches <= w_byte[3:2];
                            end
                            for (int ch = 0; ch < NUM_JOY; ch++) begin
                                if (r_byte_cnt == 16'd1 && w_joy_sel == 3'(ch))
                                    r_joy[ch*JOY_W +: JOY_W] <= w_byte[JOY_W-1:0];
                            end
                            if (r_cmd == 8'h15) begin
                                for (int k = 0; k < STATUS_W/8; k++) begin
                                    if (r_byte_cnt == 16'(k+1))
                                        r_status[8*k +: 8] <= w_byte;
                                end
                            end
                        end
                    end
                end
                // Falling edge with bit_cnt==0 means a byte just completed:
                // fetch the next outgoing byte; otherwise shift the current one.
                if (w_sck_fall) begin
                    if (r_bit_cnt == 3'd0) begin
                        r_tx   <= w_tx_next;
                        r_miso <= w_tx_next[7];
                    end else begin
                        r_miso <= r_tx[3'd7 - r_bit_cnt];
                    end
                end
            end
        end
    end

    assign SPI_MISO = SPI_SS_IO ? 1'bz : r_miso;
    assign JOY      = r_joy;
    assign BUTTONS  = r_buttons;
    assign SWITCHES = r_switches;
    assign status   = r_status;

    // ---------------------------------------------------------------- FIFO
    logic [7:0]    r_mem [PS2_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          w_full, w_empty, w_pop, w_accept;
    logic [7:0]    w_head;

    assign w_full   = (r_count == CW'(PS2_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_head   = r_mem[r_rd_ptr];
    // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
    assign w_accept = w_push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_accept)
            r_mem[r_wr_ptr] <= w_byte;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && !w_accept)
                r_overflow <= 1'b1;
        end
    end

    assign ps2_overflow = r_overflow;

    // ---------------------------------------------------------------- PS/2
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} ps2_state_t;

    ps2_state_t       r_state, w_state_nxt;
    logic [DIV_W-1:0] r_div, w_div_nxt;
    logic [3:0]       r_bit, w_bit_nxt;
    logic             r_low, w_low_nxt;
    logic [9:0]       r_frame, w_frame_nxt;   // {stop, parity, d7..d0}
    logic             r_ps2_clk, r_ps2_data, w_clk_nxt, w_data_nxt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_bit      <= 4'd0;
            r_low      <= 1'b0;
            r_frame    <= 10'd0;
            r_ps2_clk  <= 1'b1;
            r_ps2_data <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_div      <= w_div_nxt;
            r_bit      <= w_bit_nxt;
            r_low      <= w_low_nxt;
            r_frame    <= w_frame_nxt;
            r_ps2_clk  <= w_clk_nxt;
            r_ps2_data <= w_data_nxt;
        end
    end

    // Outputs are registered, so ps2_clk follows r_low by one cycle; a new
    // data bit is therefore always driven one cycle before ps2_clk falls.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_bit_nxt   = r_bit;
        w_low_nxt   = r_low;
        w_frame_nxt = r_frame;
        w_clk_nxt   = 1'b1;
        w_data_nxt  = r_ps2_data;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_data_nxt = 1'b1;
                if (!w_empty)
                    w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_pop       = 1'b1;
                w_frame_nxt = {1'b1, ~^w_head, w_head};
                w_data_nxt  = 1'b0;
                w_div_nxt   = DIV_W'(PS2_DIV - 1);
                w_bit_nxt   = 4'd0;
                w_low_nxt   = 1'b1;
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                w_clk_nxt = ~r_low;
                if (r_div == '0) begin
                    w_div_nxt = DIV_W'(PS2_DIV - 1);
                    if (r_low) begin
                        w_low_nxt = 1'b0;
                    end else if (r_bit == 4'd10) begin
                        w_data_nxt  = 1'b1;
                        w_state_nxt = S_GAP;
                    end else begin
                        w_bit_nxt   = r_bit + 4'd1;
                        w_low_nxt   = 1'b1;
                        w_data_nxt  = r_frame[0];
                        w_frame_nxt = {1'b1, r_frame[9:1]};
                    end
                end else begin
                    w_div_nxt = r_div - DIV_W'(1);
                end
            end
            S_GAP: begin
                w_data_nxt = 1'b1;
                if (r_div == '0)
                    w_state_nxt = S_IDLE;
                else
                    w_div_nxt = r_div - DIV_W'(1);
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign ps2_clk  = r_ps2_clk;
    assign ps2_data = r_ps2_data;

endmodule

// File: tb/tb_user_io_mc.sv
module tb_user_io_mc;

    localparam int DIV  = 20;
    localparam int HALF = 60;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] conf_str = 16'h4142;   // "AB"
    logic [7:0]  core_type = 8'hA4;
    logic        SPI_CLK = 1'b0;
    logic        SPI_SS_IO = 1'b1;
    logic        SPI_MOSI = 1'b0;
    wire         SPI_MISO;
    logic [11:0] JOY;
    logic [1:0]  BUTTONS, SWITCHES;
    logic [31:0] status;
    logic        ps2_clk, ps2_data, ps2_overflow;

    int n_checks = 0;
    int n_err    = 0;

    user_io_mc #(
        .STRLEN(2), .NUM_JOY(2), .JOY_W(6), .STATUS_W(32),
        .PS2_DEPTH(2), .PS2_DIV(DIV)
    ) dut (
        .clk(clk), .reset_n(reset_n), .conf_str(conf_str), .core_type(core_type),
        .SPI_CLK(SPI_CLK), .SPI_SS_IO(SPI_SS_IO), .SPI_MOSI(SPI_MOSI),
        .SPI_MISO(SPI_MISO), .JOY(JOY), .BUTTONS(BUTTONS), .SWITCHES(SWITCHES),
        .status(status), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ps2_overflow(ps2_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]      cmd;
        logic [2:0]      n;
        logic [4:0][7:0] d;
        logic [11:0]     joy;
        logic [1:0]      btn;
        logic [1:0]      sw;
        logic [31:0]     st;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic spi_begin();
        SPI_SS_IO = 1'b0;
        #100;
    endtask

    task automatic spi_end();
        #HALF;
        SPI_SS_IO = 1'b1;
        #200;
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            SPI_MOSI = tx[i];
            #HALF;
            SPI_CLK = 1'b1;
            rx[i] = SPI_MISO;
            #HALF;
            SPI_CLK = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] cmd, input int n, input logic [4:0][7:0] d);
        logic [7:0] rx;
        spi_begin();
        spi_xfer(cmd, 8, rx);
        for (int i = 0; i < n; i++) spi_xfer(d[i], 8, rx);
        spi_end();
    endtask

    task automatic wait_fall(input int budget, output bit ok, output int cyc);
        logic p;
        p   = ps2_clk;
        ok  = 1'b0;
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (p && !ps2_clk) begin
                ok = 1'b1;
                break;
            end
            p = ps2_clk;
        end
    endtask

    task automatic get_frame(input int budget, output logic [10:0] bits);
        bit f;
        int cyc;
        bits = '0;
        for (int b = 0; b < 11; b++) begin
            wait_fall(b == 0 ? budget : 3*DIV, f, cyc);
            if (!f) begin
                n_checks++;
                n_err++;
                $display("FAIL ps2_frame_timeout: bit %0d never clocked", b);
                return;
            end
            bits[b] = ps2_data;
            if (b > 0) chk("ps2_bit_period", 32'(cyc), 32'(2*DIV));
        end
    endtask

    function automatic logic [10:0] ps2_frame_of(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction

    logic [10:0] fr0, fr1, fr2;
    logic [7:0]  rx0, rx1, rx2, rx3, rx_tmp;
    bit          f_any;
    int          cyc_any;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err + 1);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h01, 3'd1, {8'h00,8'h00,8'h00,8'h00,8'h0E}, 12'h000, 2'b10, 2'b11, 32'h0};
        vecs[1] = '{8'h02, 3'd1, {8'h00,8'h00,8'h00,8'h00,8'h2A}, 12'h02A, 2'b10, 2'b11, 32'h0};
        vecs[2] = '{8'h03, 3'd1, {8'h00,8'h00,8'h00,8'h00,8'h15}, 12'h56A, 2'b10, 2'b11, 32'h0};
        vecs[3] = '{8'h10, 3'd1, {8'h00,8'h00,8'h00,8'h00,8'h3F}, 12'h56A, 2'b10, 2'b11, 32'h0};
        vecs[4] = '{8'h15, 3'd5, {8'h05,8'h04,8'h03,8'h02,8'h01}, 12'h56A, 2'b10, 2'b11, 32'h04030201};
        vecs[5] = '{8'h02, 3'd1, {8'h00,8'h00,8'h00,8'h00,8'hFF}, 12'h57F, 2'b10, 2'b11, 32'h04030201};
        vecs[6] = '{8'h07, 3'd1, {8'h00,8'h00,8'h00,8'h00,8'h55}, 12'h57F, 2'b10, 2'b11, 32'h04030201};
        vecs[7] = '{8'h01, 3'd2, {8'h00,8'h00,8'h00,8'h0A,8'h05}, 12'h57F, 2'b01, 2'b01, 32'h04030201};
        vecs[8] = '{8'h11, 3'd1, {8'h00,8'h00,8'h00,8'h00,8'h22}, 12'h57F, 2'b01, 2'b01, 32'h04030201};
        vecs[9] = '{8'h15, 3'd1, {8'h00,8'h00,8'h00,8'h00,8'hAA}, 12'h57F, 2'b01, 2'b01, 32'h040302AA};

        // reset
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_joy", 32'(JOY), 32'h0);
        chk("rst_buttons", 32'(BUTTONS), 32'h0);
        chk("rst_switches", 32'(SWITCHES), 32'h0);
        chk("rst_status", status, 32'h0);
        chk("rst_ps2_clk", 32'(ps2_clk), 32'h1);
        chk("rst_ps2_data", 32'(ps2_data), 32'h1);
        chk("rst_overflow", 32'(ps2_overflow), 32'h0);

        // register-write table
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].cmd, int'(vecs[i].n), vecs[i].d);
            chk($sformatf("v%0d_joy", i), 32'(JOY), 32'(vecs[i].joy));
            chk($sformatf("v%0d_buttons", i), 32'(BUTTONS), 32'(vecs[i].btn));
            chk($sformatf("v%0d_switches", i), 32'(SWITCHES), 32'(vecs[i].sw));
            chk($sformatf("v%0d_status", i), status, vecs[i].st);
        end

        // core type and config string readout
        spi_begin();
        spi_xfer(8'h14, 8, rx0);
        spi_xfer(8'h00, 8, rx1);
        spi_xfer(8'h00, 8, rx2);
        spi_xfer(8'h00, 8, rx3);
        spi_end();
        chk("miso_core_type", 32'(rx0), 32'hA4);
        chk("miso_conf0", 32'(rx1), 32'h41);
        chk("miso_conf1", 32'(rx2), 32'h42);
        chk("miso_conf_past_end", 32'(rx3), 32'h00);

        // abort mid data byte, then a fresh transaction restarts counting
        spi_begin();
        spi_xfer(8'h15, 8, rx_tmp);
        spi_xfer(8'hEE, 4, rx_tmp);
        spi_end();
        chk("abort_status", status, 32'h040302AA);
        send(8'h15, 1, {8'h00,8'h00,8'h00,8'h00,8'h01});
        chk("after_abort_status", status, 32'h04030201);

        // single PS/2 frame
        fork
            send(8'h05, 1, {8'h00,8'h00,8'h00,8'h00,8'h1C});
            get_frame(3000, fr0);
        join
        chk("ps2_frame_1C", 32'(fr0), 32'h438);
        chk("ps2_no_overflow", 32'(ps2_overflow), 32'h0);

        // overflow: 4 bytes into a depth-2 FIFO while the first is sending
        fork
            send(8'h05, 4, {8'h00,8'h44,8'h33,8'h22,8'h11});
            begin
                get_frame(3000, fr0);
                get_frame(3000, fr1);
                get_frame(3000, fr2);
            end
        join
        chk("ovf_frame0", 32'(fr0), 32'(ps2_frame_of(8'h11)));
        chk("ovf_frame1", 32'(fr1), 32'(ps2_frame_of(8'h22)));
        chk("ovf_frame2", 32'(fr2), 32'(ps2_frame_of(8'h33)));
        wait_fall(40*DIV, f_any, cyc_any);
        chk("ovf_no_4th_frame", 32'(f_any), 32'h0);
        chk("ovf_flag_set", 32'(ps2_overflow), 32'h1);

        // reset in the middle of a frame
        send(8'h05, 1, {8'h00,8'h00,8'h00,8'h00,8'h5A});
        wait_fall(3000, f_any, cyc_any);
        chk("midframe_started", 32'(f_any), 32'h1);
        @(negedge clk) reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_ps2_clk", 32'(ps2_clk), 32'h1);
        chk("midrst_ps2_data", 32'(ps2_data), 32'h1);
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_overflow", 32'(ps2_overflow), 32'h0);
        chk("midrst_status", status, 32'h0);
        chk("midrst_joy", 32'(JOY), 32'h0);
        chk("midrst_buttons", 32'(BUTTONS), 32'h0);
        wait_fall(30*DIV, f_any, cyc_any);
        chk("midrst_ps2_quiet", 32'(f_any), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/user_io_mc.md
Name: user_io_mc

Overview:
- Parametrised successor to the MiST user-I/O SPI slave. Sits between the IO-controller SPI link and the core.
- Supports up to 4 joysticks of configurable width, 8- or 32-bit status, and a configurable OSD config string.
- Adds a buffered PS/2 keyboard transmitter with overflow flag.
- Fully single-clock: SPI pins are oversampled in the clk domain.

Parameters:
- STRLEN, 1, config string length in bytes.
- NUM_JOY, 2, joystick channels, 1..4.
- JOY_W, 6, bits per joystick, 1..8.
- STATUS_W, 8, status width, 8 or 32.
- PS2_DEPTH, 16, PS/2 FIFO depth in bytes, power of two, >=2.
- PS2_DIV, 750, clk cycles per PS/2 half-bit.

Ports:
- clk  in  1  system clock; must be >=4x SPI_CLK frequency.
- reset_n  in  1  synchronous active-low reset.
- conf_str  in  8*STRLEN  OSD config string; first character in the MSB byte.
- core_type  in  8  core identifier byte.
- SPI_CLK  in  1  SPI clock from the IO controller.
- SPI_SS_IO  in  1  SPI select, active low.
- SPI_MOSI  in  1  SPI data in.
- SPI_MISO  out  1  SPI data out; high-Z while SPI_SS_IO is high.
- JOY  out  NUM_JOY*JOY_W  joystick bits; channel n occupies [n*JOY_W +: JOY_W].
- BUTTONS  out  2  board buttons.
- SWITCHES  out  2  board switches.
- status  out  STATUS_W  OSD status bits.
- ps2_clk  out  1  PS/2 clock, idle high.
- ps2_data  out  1  PS/2 data, idle high.
- ps2_overflow  out  1  sticky flag: a keyboard byte was dropped.

Behaviour:
- Reset: All clk-domain registers use the single reset: reset_n sampled low on a clk rising edge clears state on that edge.
  - Reset values: JOY=0, BUTTONS=0, SWITCHES=0, status=0, ps2_clk=1, ps2_data=1, ps2_overflow=0.
  - Reset also empties the FIFO, sets the transmitter idle and clears the byte/bit counters.
- Input sync:
  - SPI_CLK, SPI_SS_IO and SPI_MOSI each pass through 2 sync flops.
  - A rising/falling SPI_CLK edge is detected from the synced copy plus 1 history register.
- Transaction framing:
  - A transaction starts when synced SS goes low; bit and byte counters are zeroed.
  - MOSI is sampled on each detected rising edge, MSB first.
  - After 8 bits, byte_cnt increments. Byte 0 is the command; bytes >=1 are data.
  - SS high at any time aborts: partial bytes are discarded, and registers already written keep their values.
- MISO:
  - Updated on each detected falling edge, MSB first.
  - During byte 0, MISO carries core_type.
  - During cmd 0x14 data bytes, MISO carries conf string byte (byte_cnt-1), or 0x00 once byte_cnt-1 >= STRLEN.
  - Otherwise MISO=0.
- Commands (each acts on completion of data byte 1 unless stated):
  - 0x01: BUTTONS=d[1:0], SWITCHES=d[3:2].
  - 0x02, 0x03, 0x10, 0x11: joystick 0, 1, 2, 3 = d[JOY_W-1:0]. A channel index >= NUM_JOY is ignored.
  - 0x05: every data byte is pushed into the PS/2 FIFO.
  - 0x14: read-only conf string readout.
  - 0x15: data byte k writes status[8k+7:8k] for k < STATUS_W/8; further bytes are ignored.
  - Unknown commands: data bytes are ignored.
- Output latency: a register update is visible <=4 clk cycles after the SPI_CLK rising edge of the byte's last bit.
- FIFO:
  - A push while full drops the byte and sets ps2_overflow; the flag is cleared only by reset.
  - Simultaneous push and pop when full: pop first, the push is accepted.
- PS/2 transmitter:
  - When idle and the FIFO is not empty, pop one byte and send 11 bits: start 0, d0..d7, odd parity, stop 1.
  - Each bit: ps2_data set while ps2_clk is high; ps2_clk low for PS2_DIV cycles, then high for PS2_DIV cycles.
  - 1 idle half-bit (ps2_clk=1, ps2_data=1) separates frames.
  - States: IDLE -> LOAD -> SHIFT (11 bits) -> GAP -> IDLE.
- Reset mid-frame: the transmitter returns to IDLE immediately with both lines high.

Test Plan:
- Reset: assert reset_n low 2 cycles -> all outputs at reset values. SPI_MISO=Z with SS high.
- Core type: SS low, shift cmd 0x14 plus 3 data bytes with STRLEN=2, conf="AB" -> MISO returns 0xA4 (core_type), 0x41, 0x42, 0x00.
- Joysticks: NUM_JOY=2, JOY_W=6, send 0x02/0x2A and 0x10/0x3F -> JOY[5:0]=0x2A; channel 2 ignored, JOY unchanged otherwise.
- Status: STATUS_W=32, send 0x15 then 0x01,0x02,0x03,0x04,0x05 -> status=0x04030201.
  - Abort case: raise SS after 4 bits of the first data byte -> status unchanged.
- PS/2 frame: send 0x05/0x1C -> ps2_data sequence 0,0,0,1,1,1,0,0,0,0,1 (start, data LSB first, parity 0, stop), each bit lasting 2*PS2_DIV clocks.
- Overflow: PS2_DEPTH=2, push 4 bytes back-to-back -> transmitter emits the first bytes in order, at least one byte is dropped, ps2_overflow=1 until reset.
